// File: rtl/disp_frame_sched.sv
// Display refresh scheduler: captures game frames, prepends the invincibility bar and
// shifts 30-bit words MSB-first into a 74HC595-style chain; blinks the last frame on gameover.
module disp_frame_sched #(
  parameter int CLK_DIV   = 4,
  parameter int BLINK_CYC = 12500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [22:0] disdata,
  input  logic        dis,
  input  logic        gameover,
  input  logic [6:0]  wudidis,
  output logic        sclk,
  output logic        sdata,
  output logic        slatch,
  output logic        busy,
  output logic [7:0]  frame_cnt,
  output logic [7:0]  ovr_cnt
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(BLINK_CYC);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div_cnt;
  logic          div_done;
  logic [4:0]    bit_idx;
  logic [29:0]   word;
  logic          word_is_blink;
  logic [22:0]   pend, last_frame, payload;
  logic          pend_valid;
  logic          go_q, go_rise, go_fall;
  logic          phase, blink_req;
  logic [BW-1:0] blink_cnt;
  logic          req, consume;

  // Handshake: dis is a one-cycle valid with no ready. The controller never stalls; a
  // pending frame that is replaced before LOAD consumes it is dropped and counted in ovr_cnt.
  assign go_rise  = gameover & ~go_q;
  assign go_fall  = ~gameover & go_q;
  assign req      = gameover ? blink_req : pend_valid;
  assign consume  = (state == LOAD) && !gameover;
  assign payload  = gameover ? (phase ? last_frame : 23'd0) : pend;
  assign div_done = (div_cnt == DIV_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (req) state_nxt = LOAD;
      LOAD:     state_nxt = SHIFT_LO;
      SHIFT_LO: if (div_done) state_nxt = SHIFT_HI;
      SHIFT_HI: if (div_done) state_nxt = (bit_idx == 5'd0) ? LATCH : SHIFT_LO;
      LATCH:    if (div_done) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Serializer: outputs are registered from the next state so sclk/slatch are glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      div_cnt       <= '0;
      bit_idx       <= 5'd0;
      word          <= 30'd0;
      word_is_blink <= 1'b0;
      last_frame    <= 23'd0;
      sclk          <= 1'b0;
      sdata         <= 1'b0;
      slatch        <= 1'b0;
      busy          <= 1'b0;
      frame_cnt     <= 8'd0;
    end else begin
      state  <= state_nxt;
      sclk   <= (state_nxt == SHIFT_HI);
      slatch <= (state_nxt == LATCH);
      busy   <= (state_nxt != IDLE);
      if ((state == SHIFT_LO || state == SHIFT_HI || state == LATCH) && !div_done)
        div_cnt <= div_cnt + DW'(1);
      else
        div_cnt <= '0;
      case (state)
        LOAD: begin
          word          <= {wudidis, payload};
          bit_idx       <= 5'd29;
          sdata         <= wudidis[6];
          word_is_blink <= gameover;
        end
        SHIFT_HI: if (div_done && bit_idx != 5'd0) begin
          bit_idx <= bit_idx - 5'd1;
          sdata   <= word[bit_idx - 5'd1];
        end
        LATCH: if (div_done) begin
          frame_cnt <= frame_cnt + 8'd1;
          if (!word_is_blink) last_frame <= word[22:0];
        end
        default: ;
      endcase
    end
  end

  // Frame capture and gameover blink timing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend       <= 23'd0;
      pend_valid <= 1'b0;
      ovr_cnt    <= 8'd0;
      go_q       <= 1'b0;
      phase      <= 1'b0;
      blink_req  <= 1'b0;
      blink_cnt  <= '0;
    end else begin
      go_q <= gameover;
      if (go_rise) begin
        pend_valid <= 1'b0;
      end else if (go_fall) begin
        // Redraw the game frame unless a fresh one arrives on the same edge.
        pend_valid <= 1'b1;
        pend       <= dis ? disdata : last_frame;
      end else if (!gameover && dis) begin
        pend       <= disdata;
        pend_valid <= 1'b1;
        if (pend_valid && !consume && ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
      end else if (consume) begin
        pend_valid <= 1'b0;
      end

      if (go_rise) begin
        blink_cnt <= '0;
        phase     <= 1'b0;
        blink_req <= 1'b1;
      end else if (gameover) begin
        if (state == LOAD) blink_req <= 1'b0;
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          phase     <= ~phase;
          blink_req <= 1'b1;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end else begin
        blink_cnt <= '0;
        phase     <= 1'b0;
        blink_req <= 1'b0;
      end
    end
  end

endmodule
